// File: rtl/stopwatch_ctrl.sv
// Control sequencer for the two-digit BCD stopwatch: button conditioning,
// fixed-priority arbitration, IDLE/RUN/STOP state machine, tick prescaler,
// lap display timer and registered control strobes.
module stopwatch_ctrl #(
    parameter int unsigned CLK_DIV   = 1200000,
    parameter int unsigned DEBOUNCE  = 16,
    parameter int unsigned LAP_TICKS = 20
) (
    input  logic CLK,
    input  logic RST,
    input  logic btn_clear,
    input  logic btn_stop,
    input  logic btn_lap,
    input  logic btn_start,
    output logic count_en,
    output logic clear,
    output logic lap_capture,
    output logic show_lap,
    output logic running
);

    localparam int unsigned PW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int unsigned LW = $clog2(LAP_TICKS + 1);
    localparam int unsigned DW = $clog2(DEBOUNCE);

    // Button index order inside the conditioning vectors.
    localparam int unsigned B_START = 0;
    localparam int unsigned B_LAP   = 1;
    localparam int unsigned B_STOP  = 2;
    localparam int unsigned B_CLEAR = 3;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        STOP = 2'd2
    } state_t;

    logic [3:0]    raw;
    logic [3:0]    s1;
    logic [3:0]    s2;
    logic [3:0]    deb;
    logic [3:0]    deb_q;
    logic [DW-1:0] db_cnt [4];
    logic [3:0]    press;
    logic [3:0]    grant;

    state_t        state;
    state_t        state_nxt;
    logic [PW-1:0] presc;
    logic [PW-1:0] presc_nxt;
    logic          tick;
    logic          presc_zero;
    logic [LW-1:0] lap_timer;
    logic [LW-1:0] lap_timer_nxt;
    logic          clear_nxt;
    logic          lap_nxt;
    logic          count_en_nxt;

    assign raw = {btn_clear, btn_stop, btn_lap, btn_start};

    // Two-flop synchronisers, debounce counters and press-edge history.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            s1    <= '0;
            s2    <= '0;
            deb   <= '0;
            deb_q <= '0;
            for (int unsigned i = 0; i < 4; i++) begin
                db_cnt[i] <= '0;
            end
        end else begin
            s1    <= raw;
            s2    <= s1;
            deb_q <= deb;
            for (int unsigned i = 0; i < 4; i++) begin
                if (s2[i] == deb[i]) begin
                    db_cnt[i] <= '0;
                end else if (db_cnt[i] == DW'(DEBOUNCE - 1)) begin
                    deb[i]    <= s2[i];
                    db_cnt[i] <= '0;
                end else begin
                    db_cnt[i] <= db_cnt[i] + DW'(1);
                end
            end
        end
    end

    // Press events and fixed-priority one-hot grant (clear > stop > lap > start).
    always_comb begin
        press = deb & ~deb_q;
        grant = '0;
        if (press[B_CLEAR]) begin
            grant[B_CLEAR] = 1'b1;
        end else if (press[B_STOP]) begin
            grant[B_STOP] = 1'b1;
        end else if (press[B_LAP]) begin
            grant[B_LAP] = 1'b1;
        end else if (press[B_START]) begin
            grant[B_START] = 1'b1;
        end
    end

    assign tick = (presc == PW'(CLK_DIV - 1));

    // State register.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state, strobe decode, prescaler and lap timer next values.
    always_comb begin
        state_nxt  = state;
        clear_nxt  = 1'b0;
        lap_nxt    = 1'b0;
        presc_zero = 1'b0;

        if (grant[B_CLEAR]) begin
            state_nxt  = IDLE;
            clear_nxt  = 1'b1;
            presc_zero = 1'b1;
        end else if (grant[B_STOP]) begin
            if (state == RUN) begin
                state_nxt = STOP;
            end
        end else if (grant[B_LAP]) begin
            if (state != IDLE) begin
                lap_nxt = 1'b1;
            end
        end else if (grant[B_START]) begin
            if (state == IDLE) begin
                state_nxt  = RUN;
                presc_zero = 1'b1;
            end else if (state == STOP) begin
                // Resume from a pause keeps the prescaler phase.
                state_nxt = RUN;
            end
        end

        if (presc_zero || tick) begin
            presc_nxt = '0;
        end else begin
            presc_nxt = presc + PW'(1);
        end

        // Reload takes precedence over a coincident tick decrement.
        if (clear_nxt) begin
            lap_timer_nxt = '0;
        end else if (lap_nxt) begin
            lap_timer_nxt = LW'(LAP_TICKS);
        end else if (tick && (lap_timer != '0)) begin
            lap_timer_nxt = lap_timer - LW'(1);
        end else begin
            lap_timer_nxt = lap_timer;
        end

        count_en_nxt = tick && (state == RUN) && !clear_nxt;
    end

    // Prescaler, lap timer and registered outputs.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            presc       <= '0;
            lap_timer   <= '0;
            count_en    <= 1'b0;
            clear       <= 1'b0;
            lap_capture <= 1'b0;
            show_lap    <= 1'b0;
            running     <= 1'b0;
        end else begin
            presc       <= presc_nxt;
            lap_timer   <= lap_timer_nxt;
            count_en    <= count_en_nxt;
            clear       <= clear_nxt;
            lap_capture <= lap_nxt;
            show_lap    <= (lap_timer_nxt != '0);
            running     <= (state_nxt == RUN);
        end
    end

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Self-checking bench for stopwatch_ctrl with DEBOUNCE=4, CLK_DIV=10,
// LAP_TICKS=3: a directed vector table plus hand-written lap and reset runs.
module tb_stopwatch_ctrl;

    logic CLK = 1'b0;
    logic RST;
    logic btn_clear, btn_stop, btn_lap, btn_start;
    logic count_en, clear, lap_capture, show_lap, running;
    logic [4:0] outv;

    int checks   = 0;
    int failures = 0;

    stopwatch_ctrl #(
        .CLK_DIV  (10),
        .DEBOUNCE (4),
        .LAP_TICKS(3)
    ) dut (
        .CLK        (CLK),
        .RST        (RST),
        .btn_clear  (btn_clear),
        .btn_stop   (btn_stop),
        .btn_lap    (btn_lap),
        .btn_start  (btn_start),
        .count_en   (count_en),
        .clear      (clear),
        .lap_capture(lap_capture),
        .show_lap   (show_lap),
        .running    (running)
    );

    always #5 CLK = ~CLK;

    assign outv = {count_en, clear, lap_capture, show_lap, running};

    typedef struct {
        logic [3:0]  btn;   // {clear, stop, lap, start}
        int unsigned n;     // edges to advance before comparing
        logic [4:0]  exp;   // {count_en, clear, lap_capture, show_lap, running}
    } vec_t;

    localparam int NV = 26;
    vec_t tbl [NV];

    task automatic edges(input int unsigned n);
        repeat (n) @(posedge CLK);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int unsigned cnt;

        // Edges are counted from the drive point that precedes them.
        tbl[0]  = '{4'b0000, 3, 5'b00000};
        tbl[1]  = '{4'b0001, 6, 5'b00000};  // start: edge 6, not yet
        tbl[2]  = '{4'b0001, 1, 5'b00001};  // edge 7: RUN
        tbl[3]  = '{4'b0000, 9, 5'b00001};
        tbl[4]  = '{4'b0000, 1, 5'b10001};  // 10 cycles after start
        tbl[5]  = '{4'b0000, 1, 5'b00001};
        tbl[6]  = '{4'b0000, 9, 5'b10001};
        tbl[7]  = '{4'b0100, 1, 5'b00001};  // stop bounce 1,0,1,0
        tbl[8]  = '{4'b0000, 1, 5'b00001};
        tbl[9]  = '{4'b0100, 1, 5'b00001};
        tbl[10] = '{4'b0000, 1, 5'b00001};
        tbl[11] = '{4'b0100, 5, 5'b00001};  // stable high
        tbl[12] = '{4'b0100, 1, 5'b10001};  // last tick still in RUN
        tbl[13] = '{4'b0100, 1, 5'b00000};  // 7th edge of stable level: STOP
        tbl[14] = '{4'b0000, 9, 5'b00000};  // no count_en in STOP
        tbl[15] = '{4'b0001, 6, 5'b00000};  // resume
        tbl[16] = '{4'b0001, 1, 5'b00001};
        tbl[17] = '{4'b0000, 2, 5'b00001};
        tbl[18] = '{4'b0000, 1, 5'b10001};  // phase kept: 3 cycles, not 10
        tbl[19] = '{4'b0000, 1, 5'b00001};
        tbl[20] = '{4'b1001, 6, 5'b00001};  // clear+start together
        tbl[21] = '{4'b1001, 1, 5'b01000};  // clear wins, IDLE
        tbl[22] = '{4'b0000, 1, 5'b00000};
        tbl[23] = '{4'b0000, 5, 5'b00000};
        tbl[24] = '{4'b0010, 7, 5'b00000};  // lap in IDLE ignored
        tbl[25] = '{4'b0000, 3, 5'b00000};

        RST = 1'b1;
        {btn_clear, btn_stop, btn_lap, btn_start} = 4'b0000;
        edges(2);
        check("reset_outputs", outv, 5'b00000);
        btn_start = 1'b1;
        edges(3);
        check("reset_hold_btn", outv, 5'b00000);
        btn_start = 1'b0;
        edges(2);
        RST = 1'b0;

        for (int i = 0; i < NV; i++) begin
            {btn_clear, btn_stop, btn_lap, btn_start} = tbl[i].btn;
            edges(tbl[i].n);
            check($sformatf("vec%0d", i), outv, tbl[i].exp);
        end

        // Lap display: start at edge S, lap accepted on tick edge S+10.
        btn_start = 1'b1;
        edges(7);
        check("lap_start_run", running, 1'b1);
        btn_start = 1'b0;
        edges(3);
        btn_lap = 1'b1;
        edges(6);
        check("lap_pre_capture", {lap_capture, show_lap}, 2'b00);
        edges(1);
        check("lap_capture1", {count_en, lap_capture, show_lap}, 3'b111);
        btn_lap = 1'b0;
        cnt = 0;
        while (show_lap && cnt < 200) begin
            cnt++;
            edges(1);
            if (cnt == 1) check("lap_capture1_single", lap_capture, 1'b0);
        end
        check("lap_show_len1", cnt, 30);

        // Second display, then a reload two ticks in.
        edges(3);
        btn_lap = 1'b1;
        edges(7);
        check("lap_capture2", {lap_capture, show_lap}, 2'b11);
        btn_lap = 1'b0;
        edges(13);
        btn_lap = 1'b1;
        edges(6);
        check("lap_before_reload", {lap_capture, show_lap}, 2'b01);
        edges(1);
        check("lap_reload_capture", {lap_capture, show_lap}, 2'b11);
        btn_lap = 1'b0;
        cnt = 0;
        while (show_lap && cnt < 200) begin
            cnt++;
            edges(1);
        end
        check("lap_show_len_reload", cnt, 30);

        // Reset mid lap display with a start press inside the debouncer.
        btn_lap = 1'b1;
        edges(7);
        check("rst_pre_lap", {lap_capture, show_lap, running}, 3'b111);
        btn_lap   = 1'b0;
        btn_start = 1'b1;
        edges(3);
        #2 RST = 1'b1;
        #1 check("rst_async_clear", outv, 5'b00000);
        edges(2);
        check("rst_held", outv, 5'b00000);
        RST = 1'b0;
        for (int k = 1; k <= 6; k++) begin
            edges(1);
            check($sformatf("post_rst_quiet%0d", k), outv, 5'b00000);
        end
        edges(1);
        check("post_rst_full_press", outv, 5'b00001);
        btn_start = 1'b0;
        edges(2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
